// File: rtl/axbtb_update_sender.sv
// Approximate-BCC BTB update sender: gathers taken apBCC branch results from all lanes into a FIFO
// and emits one update per cycle over valid/ready. Optional macro: AXBTB_UPDATE_COALESCE_EN (redundant-update filtering).
module axbtb_update_sender #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES-1:0]                      brValid,
    input  logic [LANES-1:0]                      brExecTaken,
    input  logic [LANES-1:0]                      brIsApBCC,
    input  logic [LANES-1:0]                      brIsCondBr,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]      brAddr,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]      brNextAddr,
    input  logic                                  flush,
    output logic                                  updValid,
    input  logic                                  updReady,
    output logic [ADDR_WIDTH-1:0]                 updAddr,
    output logic [ADDR_WIDTH-1:0]                 updTarget,
    output logic                                  updIsCondBr,
    output logic [$clog2(DEPTH):0]                occupancy,
    output logic [15:0]                           dropCount
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ADDR_WIDTH-1:0] target;
        logic                  is_cond;
    } entry_t;

    typedef enum logic {ST_EMPTY, ST_ACTIVE} state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     drop_q, drop_d;

    logic [LANES-1:0] elig;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    n_push;
    logic [CW-1:0]    n_drop;
    logic [16:0]      drop_sum;
    logic             pop;
    logic             redundant;

    assign elig = brValid & brExecTaken & brIsApBCC;

    // Push/pop/flush bookkeeping and state transitions
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_d     = drop_q;
        free_slots = CW'(DEPTH) - count_q;
        n_push     = '0;
        n_drop     = '0;
        drop_sum   = '0;
        redundant  = 1'b0;
        pop        = (state_q == ST_ACTIVE) && updReady;

        for (int i = 0; i < LANES; i++) begin
            redundant = 1'b0;
`ifdef AXBTB_UPDATE_COALESCE_EN
            if (count_q != '0 &&
                mem_q[PW'(tail_q - PW'(1))].addr   == brAddr[i] &&
                mem_q[PW'(tail_q - PW'(1))].target == brNextAddr[i])
                redundant = 1'b1;
            for (int j = 0; j < LANES; j++) begin
                if (j < i && elig[j] && brAddr[j] == brAddr[i] && brNextAddr[j] == brNextAddr[i])
                    redundant = 1'b1;
            end
`endif
            if (elig[i] && !redundant) begin
                if (n_push < free_slots) begin
                    mem_d[PW'(tail_q + PW'(n_push))] = '{addr: brAddr[i], target: brNextAddr[i],
                                                         is_cond: brIsCondBr[i]};
                    n_push = n_push + CW'(1);
                end else begin
                    n_drop = n_drop + CW'(1);
                end
            end
        end

        if (flush) begin
            mem_d   = mem_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_EMPTY;
        end else begin
            if (pop)
                head_d = PW'(head_q + PW'(1));
            tail_d   = PW'(tail_q + PW'(n_push));
            count_d  = count_q + n_push - CW'(pop);
            drop_sum = {1'b0, drop_q} + 17'(n_drop);
            drop_d   = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
            case (state_q)
                ST_EMPTY:  if (n_push != '0) state_d = ST_ACTIVE;
                ST_ACTIVE: if (count_d == '0) state_d = ST_EMPTY;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Head entry is read straight from storage, so upd* never depends on br* in the same cycle
    assign updValid    = (state_q == ST_ACTIVE);
    assign updAddr     = mem_q[head_q].addr;
    assign updTarget   = mem_q[head_q].target;
    assign updIsCondBr = mem_q[head_q].is_cond;
    assign occupancy   = count_q;
    assign dropCount   = drop_q;

endmodule

// File: doc/axbtb_update_sender.md
# axbtb_update_sender

Write-side producer for the approximate-BCC branch target buffer. It collects resolved branch results from all integer issue lanes each cycle, keeps only taken approximate-BCC branches, and buffers them in a small FIFO. It then emits at most one update request per cycle toward the BTB write port over a valid/ready handshake. It sits between the IntEx stage branch-result outputs and the BTB update input, so the BTB sees a serialized, conflict-free write stream.

## Interface
Parameters:
- LANES, 2, number of branch-result lanes (INT_ISSUE_WIDTH)
- DEPTH, 8, FIFO entries; power of two, at least LANES
- ADDR_WIDTH, 32, PC width (PC_Path)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- brValid  in  LANES  lane carries a resolved branch
- brExecTaken  in  LANES  branch resolved taken
- brIsApBCC  in  LANES  branch is an approximate-BCC branch
- brIsCondBr  in  LANES  branch is conditional
- brAddr  in  LANES x ADDR_WIDTH  branch PC
- brNextAddr  in  LANES x ADDR_WIDTH  resolved target
- flush  in  1  discard all queued updates
- updValid  out  1  update request present
- updReady  in  1  BTB accepts the request this cycle
- updAddr  out  ADDR_WIDTH  branch PC of head entry
- updTarget  out  ADDR_WIDTH  target of head entry
- updIsCondBr  out  1  conditional flag of head entry
- occupancy  out  log2(DEPTH)+1  entries queued
- dropCount  out  16  saturating count of updates lost to overflow

## Operation
- Lane i is eligible when brValid[i] && brExecTaken[i] && brIsApBCC[i].
- Eligible lanes push in ascending lane order. Each push writes the entry {addr, target, isCondBr} at the tail pointer.
- Free space is DEPTH − occupancy as registered at the start of the cycle. A pop in the same cycle does not create room for a push in that cycle.
- Overflow: eligible lanes beyond the free space are dropped. dropCount increments by the number dropped and saturates at 0xFFFF.
- Pop: when updValid && updReady, the head entry is retired and the head pointer advances.
- The head and tail pointers wrap modulo DEPTH.
- The block has two states:
  - EMPTY: updValid=0. A push moves the block to ACTIVE.
  - ACTIVE: updValid=1. It returns to EMPTY when the last entry pops and there is no push in the same cycle.
- Flush: next cycle occupancy=0, pointers=0, state=EMPTY.
  - Flush takes priority over pushes and pops in the same cycle; both are discarded.
  - Flush does not change dropCount.
- Outputs are taken from the registered head entry. Nothing combinational runs from the br* inputs to the upd* outputs.

## Timing
- Reset values: updValid=0, updAddr=0, updTarget=0, updIsCondBr=0, occupancy=0, dropCount=0, state=EMPTY.
- Latency: a branch result sampled at edge t into an empty queue appears on upd* after edge t; it is visible during cycle t+1.
- Throughput: 1 update per cycle on the output. Up to LANES pushes per cycle on the input.
- updAddr, updTarget and updIsCondBr hold stable while updValid=1 && updReady=0.
- updReady while updValid=0 is ignored.
- Reset asserted mid-operation clears all state immediately (asynchronous reset); queued entries are lost.

## Configuration
- Macro AXBTB_UPDATE_COALESCE_EN.
- Defined: an eligible lane is dropped as redundant when its {addr, target} equals either of these:
  - the most recently pushed entry that is still queued, or
  - an earlier lane's eligible entry in the same cycle.
  Redundant drops do not count toward dropCount and consume no space.
- Undefined: every eligible lane is pushed. No comparators are built.

## Test plan
- Reset, then idle for 5 cycles -> updValid=0, occupancy=0, dropCount=0.
- Lane 0 eligible (addr 0x1000, target 0x2000, isCondBr 1) with updReady=1 -> one cycle later updValid=1, updAddr=0x1000, updTarget=0x2000; the entry retires and occupancy returns to 0.
- Both lanes eligible for 5 cycles with updReady=0 (DEPTH=8) -> occupancy saturates at 8, dropCount=2. Then updReady=1 drains 8 entries in FIFO order across pointer wrap.
- Both lanes eligible with identical addr 0x1000 and target 0x2000:
  - with the macro: occupancy=1;
  - without the macro: occupancy=2.
- Lane 1 has brValid=1, brExecTaken=1, brIsApBCC=0 -> no push, occupancy unchanged.
- Flush asserted together with a push and updReady=1 at occupancy 3 -> the next cycle has occupancy=0 and updValid=0; dropCount is unchanged.
